conv_window_feeder: RTL and testbench

Initiator side of the multiply/add convolution interface. It accepts a raster-order stream of 4-bit pixels and buffers the two previous image rows. For every complete 3x3 window it presents 36-bit `sample_out` and a held 36-bit `coeff_out` to the multiply/add unit, pulses `conv_en`, waits for `result_ready_in`, then forwards the 16-bit result downstream. It sits between the pixel source and `mult_add`.

---
 rtl/conv_window_feeder.sv | 150 +++++++++++++++
 tb/tb_conv_window_feeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: buffers two image rows, assembles 3x3 windows from a
// raster pixel stream and hands each window to the multiply/add unit, then
// forwards the returned result downstream.
module conv_window_feeder #(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        coeff_load,
  input  logic [35:0] coeff_data,
  output logic [35:0] coeff_out,
  output logic [35:0] sample_out,
  output logic        conv_en,
  input  logic [15:0] result_in,
  input  logic        result_ready_in,
  output logic [15:0] conv_result,
  output logic        conv_valid,
  output logic        frame_done
);

  localparam int unsigned PIX_W = 4;
  localparam int unsigned WIN_N = 9;
  localparam int unsigned XW    = $clog2(IMG_WIDTH);
  localparam int unsigned YW    = $clog2(IMG_HEIGHT);

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             conv_en_nxt;
  logic             conv_valid_nxt;
  logic             frame_done_nxt;

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             x_last;
  logic             y_last;
  logic             accept;
  logic             win_done;
  logic             last_win;

  logic [PIX_W-1:0] line1 [IMG_WIDTH];
  logic [PIX_W-1:0] line2 [IMG_WIDTH];
  logic [PIX_W-1:0] win     [WIN_N];
  logic [PIX_W-1:0] win_nxt [WIN_N];
  logic [35:0]      win_packed;

  // Ready is forced low while reset is asserted so no pixel is taken during reset
  assign pixel_ready = (state == S_ACCEPT) && !rst;
  assign accept      = pixel_valid && pixel_ready;
  assign x_last      = (x == XW'(IMG_WIDTH - 1));
  assign y_last      = (y == YW'(IMG_HEIGHT - 1));
  assign win_done    = accept && (x >= XW'(2)) && (y >= YW'(2));

  // Next window: shift left one column, new right column from line buffers and input
  always_comb begin
    win_nxt    = win;
    win_packed = '0;
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r]   = win[3*r+1];
      win_nxt[3*r+1] = win[3*r+2];
    end
    win_nxt[2] = line2[x];
    win_nxt[5] = line1[x];
    win_nxt[8] = pixel_in;
    for (int k = 0; k < WIN_N; k++) begin
      win_packed[4*k +: 4] = win_nxt[k];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCEPT;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt      = state;
    conv_en_nxt    = 1'b0;
    conv_valid_nxt = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      S_ACCEPT: begin
        if (win_done) begin
          state_nxt   = S_ISSUE;
          conv_en_nxt = 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (result_ready_in) begin
          state_nxt      = S_ACCEPT;
          conv_valid_nxt = 1'b1;
          frame_done_nxt = last_win;
        end
      end
      default: state_nxt = S_ACCEPT;
    endcase
  end

  // Position counters, registered outputs and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      last_win    <= 1'b0;
      sample_out  <= '0;
      coeff_out   <= '0;
      conv_en     <= 1'b0;
      conv_valid  <= 1'b0;
      frame_done  <= 1'b0;
      conv_result <= '0;
    end else begin
      conv_en    <= conv_en_nxt;
      conv_valid <= conv_valid_nxt;
      frame_done <= frame_done_nxt;
      if (accept) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      if (win_done) begin
        sample_out <= win_packed;
        last_win   <= x_last && y_last;
      end
      if ((state == S_WAIT) && result_ready_in) conv_result <= result_in;
      if ((state == S_ACCEPT) && coeff_load) coeff_out <= coeff_data;
    end
  end

  // Line buffers and window shift; contents need no reset since windows require y >= 2
  always_ff @(posedge clk) begin
    if (accept) begin
      line2[x] <= line1[x];
      line1[x] <= pixel_in;
      win      <= win_nxt;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x4 image, pixel value = 4y+x.
module tb_conv_window_feeder;

  logic        tb_clk;
  logic        rst;
  logic [3:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        coeff_load;
  logic [35:0] coeff_data;
  logic [35:0] coeff_out;
  logic [35:0] sample_out;
  logic        conv_en;
  logic [15:0] result_in;
  logic        result_ready_in;
  logic [15:0] conv_result;
  logic        conv_valid;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame statistics gathered by stream_frame
  int n_en, n_val, fd_cnt, fd_idx, busy_err, b2b_err, lat_err, samp_err, res_err;
  int first_en_pix, timeout;
  logic [35:0] win_log [4];

  conv_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(tb_clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .coeff_load(coeff_load), .coeff_data(coeff_data),
    .coeff_out(coeff_out), .sample_out(sample_out), .conv_en(conv_en),
    .result_in(result_in), .result_ready_in(result_ready_in),
    .conv_result(conv_result), .conv_valid(conv_valid), .frame_done(frame_done)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // Streams npix raster pixels with a responder of the given latency and records behaviour
  task automatic stream_frame(input int lat, input int npix, input logic [15:0] rv, input bit stop_at_last);
    int sent, cd, cyc_en, last_acc;
    logic rdy_pre, busy, prev_en;
    logic [35:0] held;
    sent = 0; cd = 0; cyc_en = 0; busy = 1'b0; prev_en = 1'b0; held = '0;
    n_en = 0; n_val = 0; fd_cnt = 0; fd_idx = -1; busy_err = 0; b2b_err = 0;
    lat_err = 0; samp_err = 0; res_err = 0; first_en_pix = -1; timeout = 1;
    for (int i = 0; i < 4; i++) win_log[i] = '0;
    result_ready_in = 1'b0;
    pixel_in = 4'(sent);
    pixel_valid = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy_pre = pixel_ready;
      tick();
      last_acc = -1;
      if (pixel_valid && rdy_pre) begin
        last_acc = sent;
        sent++;
      end
      result_ready_in = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          result_ready_in = 1'b1;
          result_in = rv;
        end
      end
      if (conv_en) begin
        if (busy || prev_en) b2b_err++;
        if (n_en < 4) win_log[n_en] = sample_out;
        if (n_en == 0) first_en_pix = last_acc;
        n_en++;
        busy = 1'b1;
        held = sample_out;
        cyc_en = cyc;
        cd = lat;
      end
      if (busy && pixel_ready && !conv_valid) busy_err++;
      if (busy && !conv_en && (sample_out !== held)) samp_err++;
      if (conv_valid) begin
        n_val++;
        if (conv_result !== rv) res_err++;
        if (cyc - cyc_en != lat + 1) lat_err++;
        busy = 1'b0;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_idx = conv_valid ? n_val : -1;
      end
      prev_en = conv_en;
      pixel_in = 4'(sent);
      pixel_valid = (sent < npix);
      if (sent == npix && (stop_at_last || !busy)) begin
        timeout = 0;
        break;
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = 4'h5;
    tick();
    tick();
    n_checks++; if (pixel_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pixel_ready: got %b expected 0", pixel_ready); end
    n_checks++; if (sample_out !== 36'h0) begin n_fail++; $display("FAIL rst_sample_out: got %h expected 0", sample_out); end
    n_checks++; if (coeff_out !== 36'h0) begin n_fail++; $display("FAIL rst_coeff_out: got %h expected 0", coeff_out); end
    n_checks++; if (conv_en !== 1'b0) begin n_fail++; $display("FAIL rst_conv_en: got %b expected 0", conv_en); end
    n_checks++; if (conv_result !== 16'h0) begin n_fail++; $display("FAIL rst_conv_result: got %h expected 0", conv_result); end
    n_checks++; if (conv_valid !== 1'b0) begin n_fail++; $display("FAIL rst_conv_valid: got %b expected 0", conv_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    rst = 1'b0;
    pixel_valid = 1'b0;
    #1;
    n_checks++; if (pixel_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", pixel_ready); end
  endtask

  task automatic test_window_assembly();
    stream_frame(1, 16, 16'h0123, 1'b0);
    n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL win_timeout: got %0d expected 0", timeout); end
    n_checks++; if (first_en_pix !== 10) begin n_fail++; $display("FAIL win_first_en_pixel: got %0d expected 10", first_en_pix); end
    n_checks++; if (win_log[0] !== 36'hA98654210) begin n_fail++; $display("FAIL win0: got %h expected A98654210", win_log[0]); end
    n_checks++; if (win_log[1] !== 36'hBA9765321) begin n_fail++; $display("FAIL win1: got %h expected BA9765321", win_log[1]); end
    n_checks++; if (win_log[2] !== 36'hEDCA98654) begin n_fail++; $display("FAIL win2: got %h expected EDCA98654", win_log[2]); end
    n_checks++; if (win_log[3] !== 36'hFEDBA9765) begin n_fail++; $display("FAIL win3: got %h expected FEDBA9765", win_log[3]); end
  endtask

  task automatic test_handshake();
    stream_frame(1, 16, 16'h0123, 1'b0);
    n_checks++; if (n_en !== 4) begin n_fail++; $display("FAIL hs_conv_en_count: got %0d expected 4", n_en); end
    n_checks++; if (n_val !== 4) begin n_fail++; $display("FAIL hs_conv_valid_count: got %0d expected 4", n_val); end
    n_checks++; if (res_err !== 0) begin n_fail++; $display("FAIL hs_result_value: got %0d bad results expected 0", res_err); end
    n_checks++; if (lat_err !== 0) begin n_fail++; $display("FAIL hs_valid_latency: got %0d late/early expected 0", lat_err); end
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL hs_ready_while_busy: got %0d cycles expected 0", busy_err); end
    n_checks++; if (b2b_err !== 0) begin n_fail++; $display("FAIL hs_conv_en_pulse: got %0d bad pulses expected 0", b2b_err); end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL hs_frame_done_count: got %0d expected 1", fd_cnt); end
    n_checks++; if (fd_idx !== 4) begin n_fail++; $display("FAIL hs_frame_done_position: got %0d expected 4", fd_idx); end
  endtask

  task automatic test_slow_responder();
    result_in = 16'hDEAD;
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    n_checks++; if (conv_valid !== 1'b0) begin n_fail++; $display("FAIL spurious_conv_valid: got %b expected 0", conv_valid); end
    n_checks++; if (pixel_ready !== 1'b1) begin n_fail++; $display("FAIL spurious_ready: got %b expected 1", pixel_ready); end
    stream_frame(5, 16, 16'h0456, 1'b0);
    n_checks++; if (n_en !== 4) begin n_fail++; $display("FAIL slow_conv_en_count: got %0d expected 4", n_en); end
    n_checks++; if (b2b_err !== 0) begin n_fail++; $display("FAIL slow_conv_en_repulse: got %0d expected 0", b2b_err); end
    n_checks++; if (samp_err !== 0) begin n_fail++; $display("FAIL slow_sample_stable: got %0d changes expected 0", samp_err); end
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL slow_ready_while_busy: got %0d cycles expected 0", busy_err); end
    n_checks++; if (lat_err !== 0) begin n_fail++; $display("FAIL slow_valid_latency: got %0d expected 0", lat_err); end
    n_checks++; if (n_val !== 4 || res_err !== 0) begin n_fail++; $display("FAIL slow_results: got %0d results %0d bad expected 4 and 0", n_val, res_err); end
  endtask

  task automatic test_coeff_load();
    coeff_data = 36'hFFFFFFFFF;
    coeff_load = 1'b1;
    tick();
    coeff_load = 1'b0;
    n_checks++; if (coeff_out !== 36'hFFFFFFFFF) begin n_fail++; $display("FAIL coeff_load_accept: got %h expected FFFFFFFFF", coeff_out); end
    stream_frame(1, 11, 16'h0, 1'b1);
    tick();
    coeff_data = 36'h0;
    coeff_load = 1'b1;
    tick();
    tick();
    coeff_load = 1'b0;
    n_checks++; if (coeff_out !== 36'hFFFFFFFFF) begin n_fail++; $display("FAIL coeff_load_in_wait: got %h expected FFFFFFFFF", coeff_out); end
    n_checks++; if (pixel_ready !== 1'b0) begin n_fail++; $display("FAIL coeff_wait_ready: got %b expected 0", pixel_ready); end
    result_in = 16'h0ABC;
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    n_checks++; if (conv_valid !== 1'b1 || conv_result !== 16'h0ABC) begin n_fail++; $display("FAIL coeff_wait_result: got valid=%b result=%h expected valid=1 result=0abc", conv_valid, conv_result); end
  endtask

  task automatic test_reset_mid_frame();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stream_frame(1, 11, 16'h0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    result_in = 16'hBEEF;
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    n_checks++; if (conv_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_late_valid: got %b expected 0", conv_valid); end
    n_checks++; if (conv_result !== 16'h0) begin n_fail++; $display("FAIL midrst_late_result: got %h expected 0", conv_result); end
    n_checks++; if (pixel_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", pixel_ready); end
    stream_frame(1, 16, 16'h0789, 1'b0);
    n_checks++; if (win_log[0] !== 36'hA98654210) begin n_fail++; $display("FAIL midrst_win0: got %h expected A98654210", win_log[0]); end
    n_checks++; if (n_val !== 4 || res_err !== 0) begin n_fail++; $display("FAIL midrst_results: got %0d results %0d bad expected 4 and 0", n_val, res_err); end
    n_checks++; if (fd_idx !== 4 || fd_cnt !== 1) begin n_fail++; $display("FAIL midrst_frame_done: got idx=%0d cnt=%0d expected 4 and 1", fd_idx, fd_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    pixel_in = '0;
    pixel_valid = 1'b0;
    coeff_load = 1'b0;
    coeff_data = '0;
    result_in = '0;
    result_ready_in = 1'b0;
    test_reset();
    test_window_assembly();
    test_handshake();
    test_slow_responder();
    test_coeff_load();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
